imem_fetch_buffer: RTL and testbench

Two-entry instruction fetch buffer with next-line prefetch, placed between the pipeline datapath's instruction port and a latency-variable instruction memory. The datapath presents its fetch address and reads the instruction combinationally. This block returns the instruction and a valid flag in the same cycle on a hit. On a miss it runs a req/gnt/rvalid transaction to memory. While the buffer is otherwise idle, it prefetches the next sequential word so the datapath's `imem_valid_i` stays high through straight-line code.

---
 rtl/RV32i_pkg.sv | 17 +
 rtl/fetch_entry.sv | 51 +++++
 rtl/imem_fetch_buffer.sv | 150 +++++++++++++++
 tb/tb_imem_fetch_buffer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/RV32i_pkg.sv
// Shared RV32I fetch-side types and constants used by the instruction fetch buffer.
package RV32i_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT
  } fetch_state_e;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

  // Word tag of the next sequential instruction; wraps modulo 2^32 bytes.
  function automatic logic [29:0] next_word_tag(input logic [29:0] tag);
    return tag + 30'd1;
  endfunction

endpackage

// File: rtl/fetch_entry.sv
// One fetch-buffer entry: valid/tag/data storage with a demand comparator and a
// second comparator used to ask whether the next sequential word is already held.
module fetch_entry (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        wr_i,
  input  logic [29:0] wr_tag_i,
  input  logic [31:0] wr_data_i,
  input  logic [29:0] lookup_tag_i,
  input  logic [29:0] probe_tag_i,
  output logic        hit_o,
  output logic        probe_hit_o,
  output logic [31:0] data_o
);

  logic        valid_q, valid_d;
  logic [29:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;

  // A clear in the same cycle as a write wins, so a flushed entry never revives.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (wr_i) begin
      valid_d = 1'b1;
      tag_d   = wr_tag_i;
      data_d  = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o       = valid_q && (tag_q == lookup_tag_i);
  assign probe_hit_o = valid_q && (tag_q == probe_tag_i);
  assign data_o      = data_q;

endmodule

// File: rtl/imem_fetch_buffer.sv
// Two-entry instruction fetch buffer with next-line prefetch, sitting between the
// datapath instruction port and a req/gnt/rvalid instruction memory.
module imem_fetch_buffer
  import RV32i_pkg::*;
#(
  parameter bit          PREFETCH_EN = 1'b1,
  parameter logic [31:0] NOP_INSN    = RV32I_NOP
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic [31:0] imem_add_i,
  output logic [31:0] imem_data_o,
  output logic        imem_valid_o,
  output logic        mem_req_o,
  output logic [31:0] mem_add_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  fetch_state_e state_q, state_d;
  logic         mru_q, mru_d;
  logic         drop_q, drop_d;
  logic         target_q, target_d;
  logic         mem_req_q, mem_req_d;
  logic [31:0]  mem_add_q, mem_add_d;

  logic [29:0]  lookup_tag, probe_tag;
  logic         hit_e0, hit_e1, probe_e0, probe_e1;
  logic [31:0]  data_e0, data_e1;
  logic         hit_any, hit_idx, fill_en;
  logic         unused_addr_bits;

  assign lookup_tag       = imem_add_i[31:2];
  assign probe_tag        = next_word_tag(lookup_tag);
  assign unused_addr_bits = ^imem_add_i[1:0];

  // Data returning for a flushed transaction, or arriving during a flush, is discarded.
  assign fill_en = (state_q == FETCH_WAIT) && mem_rvalid_i && !drop_q && !flush_i;

  fetch_entry u_entry0 (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (flush_i),
    .wr_i         (fill_en && !target_q),
    .wr_tag_i     (mem_add_q[31:2]),
    .wr_data_i    (mem_rdata_i),
    .lookup_tag_i (lookup_tag),
    .probe_tag_i  (probe_tag),
    .hit_o        (hit_e0),
    .probe_hit_o  (probe_e0),
    .data_o       (data_e0)
  );

  fetch_entry u_entry1 (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (flush_i),
    .wr_i         (fill_en && target_q),
    .wr_tag_i     (mem_add_q[31:2]),
    .wr_data_i    (mem_rdata_i),
    .lookup_tag_i (lookup_tag),
    .probe_tag_i  (probe_tag),
    .hit_o        (hit_e1),
    .probe_hit_o  (probe_e1),
    .data_o       (data_e1)
  );

  assign hit_any      = hit_e0 || hit_e1;
  assign hit_idx      = hit_e1;
  assign imem_valid_o = hit_any && !flush_i;
  assign imem_data_o  = !imem_valid_o ? NOP_INSN : (hit_e0 ? data_e0 : data_e1);

  always_comb begin
    state_d   = state_q;
    mru_d     = mru_q;
    drop_d    = drop_q;
    target_d  = target_q;
    mem_req_d = mem_req_q;
    mem_add_d = mem_add_q;

    unique case (state_q)
      FETCH_IDLE: begin
        drop_d = 1'b0;
        if (!flush_i) begin
          if (!hit_any) begin
            state_d   = FETCH_REQ;
            mem_req_d = 1'b1;
            mem_add_d = {lookup_tag, 2'b00};
            target_d  = !mru_q;
          end else if (PREFETCH_EN && !(probe_e0 || probe_e1)) begin
            state_d   = FETCH_REQ;
            mem_req_d = 1'b1;
            mem_add_d = {probe_tag, 2'b00};
            target_d  = !hit_idx;
          end
        end
      end
      FETCH_REQ: begin
        if (flush_i) drop_d = 1'b1;
        if (mem_gnt_i) begin
          state_d   = FETCH_WAIT;
          mem_req_d = 1'b0;
        end
      end
      FETCH_WAIT: begin
        if (flush_i) drop_d = 1'b1;
        if (mem_rvalid_i) begin
          state_d = FETCH_IDLE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d   = FETCH_IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase

    // A fill is the most recent touch of its entry; otherwise track the entry being hit.
    if (fill_en) begin
      mru_d = target_q;
    end else if (imem_valid_o) begin
      mru_d = hit_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= FETCH_IDLE;
      mru_q     <= 1'b0;
      drop_q    <= 1'b0;
      target_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_add_q <= '0;
    end else begin
      state_q   <= state_d;
      mru_q     <= mru_d;
      drop_q    <= drop_d;
      target_q  <= target_d;
      mem_req_q <= mem_req_d;
      mem_add_q <= mem_add_d;
    end
  end

  assign mem_req_o = mem_req_q;
  assign mem_add_o = mem_add_q;

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Directed bench for imem_fetch_buffer: one cycle per applyStimulus call, outputs
// sampled on the falling edge against hand-computed values.
module tb_imem_fetch_buffer;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] D0    = 32'h0050_0093;
  localparam logic [31:0] D4    = 32'h00A0_0113;
  localparam logic [31:0] D8    = 32'h0030_8193;
  localparam logic [31:0] D10   = 32'h0100_0213;
  localparam logic [31:0] D14   = 32'h0020_8293;
  localparam logic [31:0] DEC   = 32'h0000_0073;
  localparam logic [31:0] D100  = 32'h1234_5678;
  localparam logic [31:0] DBAD  = 32'hDEAD_BEEF;
  localparam logic [31:0] ATOP  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] imem_add;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic        mem_req;
  logic [31:0] mem_add;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_fetch_buffer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .flush_i      (flush),
    .imem_add_i   (imem_add),
    .imem_data_o  (imem_data),
    .imem_valid_o (imem_valid),
    .mem_req_o    (mem_req),
    .mem_add_o    (mem_add),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  // Advance one clock, drive this cycle's inputs, then settle to the falling edge.
  task automatic applyStimulus(input logic rst, input logic [31:0] a, input logic f,
                               input logic g, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    reset      = rst;
    imem_add   = a;
    flush      = f;
    mem_gnt    = g;
    mem_rvalid = rv;
    mem_rdata  = rd;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkFetch(input string tag, input logic exp_valid, input logic [31:0] exp_data);
    checkOutput({tag, ".valid"}, {31'd0, imem_valid}, {31'd0, exp_valid});
    checkOutput({tag, ".data"}, imem_data, exp_data);
  endtask

  task automatic checkBus(input string tag, input logic exp_req, input logic [31:0] exp_add);
    checkOutput({tag, ".req"}, {31'd0, mem_req}, {31'd0, exp_req});
    checkOutput({tag, ".add"}, mem_add, exp_add);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected end of sequence");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; imem_add = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset, then a cold miss at 0x0 against zero-wait memory.
    applyStimulus(1, 32'h0, 0, 0, 0, 0);   checkFetch("reset_a", 0, NOP); checkBus("reset_a", 0, 0);
    applyStimulus(1, 32'h0, 0, 0, 0, 0);   checkFetch("reset_b", 0, NOP); checkBus("reset_b", 0, 0);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);   checkFetch("cold_c0", 0, NOP); checkBus("cold_c0", 0, 0);
    applyStimulus(0, 32'h0, 0, 1, 0, 0);   checkBus("cold_c1", 1, 32'h0); checkFetch("cold_c1", 0, NOP);
    applyStimulus(0, 32'h0, 0, 0, 1, D0);  checkBus("cold_c2", 0, 32'h0); checkFetch("cold_c2", 0, NOP);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);   checkFetch("cold_c3", 1, D0);

    // Holding 0x0 prefetches 0x4; stepping to 0x4 hits and prefetches 0x8 over 0x0.
    applyStimulus(0, 32'h0, 0, 1, 0, 0);   checkBus("pf4_req", 1, 32'h4); checkFetch("pf4_hold", 1, D0);
    applyStimulus(0, 32'h0, 0, 0, 1, D4);  checkFetch("pf4_wait", 1, D0);
    applyStimulus(0, 32'h4, 0, 0, 0, 0);   checkFetch("pf4_hit", 1, D4);
    applyStimulus(0, 32'h4, 0, 1, 0, 0);   checkBus("pf8_req", 1, 32'h8);
    applyStimulus(0, 32'h4, 0, 0, 1, D8);  checkFetch("pf8_wait", 1, D4);

    // 0x0 was evicted: demand miss with two gnt and two rvalid wait states.
    applyStimulus(0, 32'h0, 0, 0, 0, 0);   checkFetch("ws_c0", 0, NOP);
    applyStimulus(0, 32'h8, 0, 0, 0, 0);   checkBus("ws_c1", 1, 32'h0); checkFetch("pf8_hit", 1, D8);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);   checkBus("ws_c2", 1, 32'h0);
    applyStimulus(0, 32'h0, 0, 1, 0, 0);   checkBus("ws_c3", 1, 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);   checkBus("ws_c4", 0, 32'h0); checkFetch("ws_c4", 0, NOP);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);   checkFetch("ws_c5", 0, NOP);
    applyStimulus(0, 32'h0, 0, 0, 1, D0);  checkFetch("ws_c6", 0, NOP);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);   checkFetch("ws_c7", 1, D0);

    // Prefetch of 0x4 completes, then a flush lands while the fetch of 0x10 is in WAIT.
    applyStimulus(0, 32'h0, 0, 1, 0, 0);   checkBus("pf4b_req", 1, 32'h4);
    applyStimulus(0, 32'h0, 0, 0, 1, D4);
    applyStimulus(0, 32'h10, 0, 0, 0, 0);  checkFetch("fl_miss", 0, NOP);
    applyStimulus(0, 32'h4, 0, 1, 0, 0);   checkBus("fl_req", 1, 32'h10); checkFetch("fl_prehit", 1, D4);
    applyStimulus(0, 32'h4, 1, 0, 0, 0);   checkFetch("fl_flushcyc", 0, NOP);
    applyStimulus(0, 32'h4, 0, 0, 1, DBAD); checkFetch("fl_cleared", 0, NOP);
    applyStimulus(0, 32'h10, 0, 0, 1, DBAD); checkFetch("fl_dropped", 0, NOP); checkBus("fl_idle", 0, 32'h10);
    applyStimulus(0, 32'h10, 0, 1, 0, 0);  checkBus("fl_rereq", 1, 32'h10); checkFetch("fl_stray", 0, NOP);
    applyStimulus(0, 32'h10, 0, 0, 1, D10);
    applyStimulus(0, 32'h10, 0, 0, 0, 0);  checkFetch("fl_refill", 1, D10);

    // Serve the 0x14 prefetch, then a hit at the top word prefetches address 0.
    applyStimulus(0, 32'h10, 0, 1, 0, 0);  checkBus("pf14_req", 1, 32'h14);
    applyStimulus(0, 32'h10, 0, 0, 1, D14);
    applyStimulus(0, ATOP, 0, 0, 0, 0);    checkFetch("wrap_miss", 0, NOP);
    applyStimulus(0, ATOP, 0, 1, 0, 0);    checkBus("wrap_dreq", 1, ATOP);
    applyStimulus(0, ATOP, 0, 0, 1, DEC);
    applyStimulus(0, ATOP, 0, 0, 0, 0);    checkFetch("wrap_hit", 1, DEC);
    applyStimulus(0, ATOP, 0, 1, 0, 0);    checkBus("wrap_pf", 1, 32'h0);
    applyStimulus(0, ATOP, 0, 0, 1, D0);

    // Jump to 0x100 while the 0x4 prefetch is still requesting.
    applyStimulus(0, 32'h0, 0, 0, 0, 0);   checkFetch("wrap_fill", 1, D0);
    applyStimulus(0, 32'h100, 0, 0, 0, 0); checkBus("dm_pfreq", 1, 32'h4); checkFetch("dm_miss", 0, NOP);
    applyStimulus(0, 32'h100, 0, 1, 0, 0); checkBus("dm_pfhold", 1, 32'h4);
    applyStimulus(0, 32'h100, 0, 0, 1, D4); checkFetch("dm_pfwait", 0, NOP);
    applyStimulus(0, 32'h100, 0, 0, 0, 0); checkBus("dm_idle", 0, 32'h4);
    applyStimulus(0, 32'h100, 0, 1, 0, 0); checkBus("dm_req", 1, 32'h100);
    applyStimulus(0, 32'h100, 0, 0, 1, D100);
    applyStimulus(0, 32'h100, 0, 0, 0, 0); checkFetch("dm_hit", 1, D100);
    applyStimulus(0, 32'h4, 0, 0, 0, 0);   checkFetch("dm_pfkept", 1, D4); checkBus("dm_pf104", 1, 32'h104);
    applyStimulus(0, 32'h0, 0, 0, 0, 0);   checkFetch("dm_evict", 0, NOP);

    // Reset during WAIT abandons the transaction; a later stray rvalid is ignored.
    applyStimulus(0, 32'h4, 0, 1, 0, 0);   checkFetch("rst_pre", 1, D4);
    applyStimulus(1, 32'h4, 0, 0, 0, 0);
    applyStimulus(0, 32'h4, 0, 0, 1, DBAD); checkBus("rst_wait", 0, 32'h0); checkFetch("rst_wait", 0, NOP);
    applyStimulus(0, 32'h4, 0, 0, 0, 0);   checkFetch("rst_stray", 0, NOP); checkBus("rst_dreq", 1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
